// File: rtl/mem_traffic_checker.sv
// Write/read traffic generator and read-back checker for the cache-to-DDR2 port.
// Optional command timeout is built when MEM_TIMEOUT_EN is defined.
module mem_traffic_checker #(
  parameter int              DATA_W      = 256,
  parameter int              ADDR_W      = 28,
  parameter int              DEPTH       = 9,
  parameter int              CYCLE_DELAY = 1,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 28'h000_1000,
  parameter int              ADDR_STRIDE = 8,
  parameter logic [31:0]     SEED        = 32'h1ACE_B00C,
  parameter int              TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              loop,
  output logic [DATA_W-1:0] mem_data_wr1,
  input  logic [DATA_W-1:0] mem_data_rd1,
  output logic [ADDR_W-1:0] mem_data_addr1,
  output logic              mem_rw_data1,
  output logic              mem_valid_data1,
  input  logic              mem_ready_data1,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       pass_count,
  output logic              timeout
);

  if (DATA_W % 32 != 0 || DEPTH < 1 || DEPTH > 256 || TIMEOUT < 1) begin : g_param_check
    $error("mem_traffic_checker: illegal parameters");
  end

  localparam int NW = DATA_W / 32;
  localparam int GW = (CYCLE_DELAY > 1) ? $clog2(CYCLE_DELAY) : 1;
  localparam logic [7:0] LAST = 8'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ADDR_STRIDE);
  localparam logic [GW-1:0] GAP_END = GW'(CYCLE_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        rd_q, rd_d;
  logic [15:0] pass_q, pass_d;
  logic        mode_q;
  logic [GW-1:0] gap_q;
  logic        accept, load, pass_end, to, mismatch;

  function automatic logic [DATA_W-1:0] pattern(
    input logic [15:0] p,
    input logic [7:0]  i
  );
    logic [31:0] w;
    pattern = '0;
    for (int k = 0; k < NW; k++) begin
      w = SEED + {p, 16'h0} + {16'h0, i, 8'h0} + 32'(k);
      pattern[k*32 +: 32] = w;
    end
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] i);
    return ADDR_BASE + ADDR_W'(i) * STRIDE_A;
  endfunction

  assign accept          = (state_q == ISSUE) && mem_ready_data1;
  assign mem_valid_data1 = (state_q == ISSUE);
  assign mismatch        = accept && rd_q && (mem_data_rd1 != mem_data_wr1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next command: mode 0 sweeps writes then reads, mode 1 pairs W/R per entry
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_d     = rd_q;
    pass_d   = pass_q;
    load     = 1'b0;
    pass_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          idx_d   = '0;
          rd_d    = 1'b0;
          pass_d  = '0;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (to) begin
          state_d = IDLE;
        end else if (accept) begin
          load = 1'b1;
          if (!rd_q) begin
            if (mode_q) begin
              rd_d = 1'b1;
            end else if (idx_q == LAST) begin
              rd_d  = 1'b1;
              idx_d = '0;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end else if (idx_q != LAST) begin
            idx_d = idx_q + 8'd1;
            rd_d  = !mode_q;
          end else begin
            pass_end = 1'b1;
            idx_d    = '0;
            rd_d     = 1'b0;
            pass_d   = pass_q + 16'd1;
          end
          if (pass_end && !loop) begin
            state_d = IDLE;
            load    = 1'b0;
          end else begin
            state_d = (CYCLE_DELAY > 0) ? GAP : ISSUE;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_END) state_d = ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q          <= '0;
      rd_q           <= 1'b0;
      pass_q         <= '0;
      mode_q         <= 1'b0;
      gap_q          <= '0;
      mem_data_wr1   <= '0;
      mem_data_addr1 <= '0;
      mem_rw_data1   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass_count     <= '0;
    end else begin
      done  <= 1'b0;
      gap_q <= (state_q == GAP) ? gap_q + 1'b1 : '0;
      if (state_q == IDLE && start) begin
        mode_q         <= mode;
        busy           <= 1'b1;
        error          <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
        pass_count     <= '0;
      end
      if (load) begin
        idx_q          <= idx_d;
        rd_q           <= rd_d;
        pass_q         <= pass_d;
        mem_data_addr1 <= addr_of(idx_d);
        mem_data_wr1   <= pattern(pass_d, idx_d);
        mem_rw_data1   <= !rd_d;
      end
      if (mismatch) begin
        error <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0) first_err_addr <= mem_data_addr1;
      end
      if (pass_end) begin
        done       <= 1'b1;
        pass_count <= pass_count + 16'd1;
        if (!loop) busy <= 1'b0;
      end
      if (to) begin
        error <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [31:0] tcnt;

  assign to = (state_q == ISSUE) && !mem_ready_data1 && (tcnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      if (state_q == IDLE && start) timeout <= 1'b0;
      else if (to)                  timeout <= 1'b1;
      tcnt <= (state_q == ISSUE && !mem_ready_data1) ? tcnt + 32'd1 : '0;
    end
  end
`else
  assign to      = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
